// File: rtl/spike_network_interface.sv
// rtl/spike_network_interface.sv - spike router front end: local delivery plus FWFT outbound flit FIFO
module spike_network_interface #(
  parameter int NUM_BITS_ADDR = 12,
  parameter int NODE_BITS     = 4,
  parameter int LOCAL_NODE    = 0,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NUM_BITS_ADDR-1:0]       spike_addr,
  input  logic                           spike_valid,
  output logic                           spike_ready,
  output logic [NUM_BITS_ADDR-1:0]       local_addr,
  output logic                           local_valid,
  output logic                           stays,
  output logic [NODE_BITS+NUM_BITS_ADDR-1:0] flit_out,
  output logic                           flit_valid,
  input  logic                           flit_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic [15:0]                    sent_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FLIT_W = NODE_BITS + NUM_BITS_ADDR;

  logic [FLIT_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     last_ptr;
  logic [NODE_BITS-1:0] dest_node;
  logic                 is_local;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 full;

  assign dest_node   = spike_addr[NUM_BITS_ADDR-1 -: NODE_BITS];
  assign is_local    = (dest_node == NODE_BITS'(LOCAL_NODE));
  assign full        = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign spike_ready = !full;
  assign accept      = spike_valid && spike_ready;
  assign push        = accept && !is_local;
  assign flit_valid  = (fifo_count != '0);
  assign pop         = flit_valid && flit_ready;
  assign last_ptr    = rd_ptr - PTR_W'(1);

  // When empty, show the most recently popped slot so flit_out holds its last value.
  assign flit_out = flit_valid ? mem[rd_ptr] : mem[last_ptr];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {NODE_BITS'(LOCAL_NODE), spike_addr};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fifo_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sent_count <= '0;
    end else if (pop) begin
      sent_count <= sent_count + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      local_addr  <= '0;
      local_valid <= 1'b0;
      stays       <= 1'b0;
    end else begin
      local_valid <= accept && is_local;
      if (accept) begin
        stays <= is_local;
        if (is_local) local_addr <= spike_addr;
      end
    end
  end

endmodule

// File: tb/tb_spike_network_interface.sv
// tb/tb_spike_network_interface.sv - scoreboard bench for spike_network_interface
module tb_spike_network_interface;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [11:0] spike_addr;
  logic        spike_valid;
  logic        spike_ready;
  logic [11:0] local_addr;
  logic        local_valid;
  logic        stays;
  logic [15:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic [2:0]  fifo_count;
  logic [15:0] sent_count;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_flits[$];
  logic [11:0] exp_locals[$];
  logic [15:0] last_flit = 16'h0;

  always #5 CLK = ~CLK;

  spike_network_interface #(
    .NUM_BITS_ADDR(12), .NODE_BITS(4), .LOCAL_NODE(0), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .spike_addr(spike_addr), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .local_addr(local_addr), .local_valid(local_valid), .stays(stays),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .fifo_count(fifo_count), .sent_count(sent_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every flit handshake and local delivery against the queues.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (flit_valid && flit_ready) begin
        if (exp_flits.size() == 0) begin
          chk("unexpected_flit", 32'(flit_out), 32'hFFFF_FFFF);
        end else begin
          last_flit = exp_flits.pop_front();
          chk("flit_order", 32'(flit_out), 32'(last_flit));
        end
      end
      if (local_valid) begin
        if (exp_locals.size() == 0) chk("unexpected_local", 32'(local_addr), 32'hFFFF_FFFF);
        else chk("local_addr", 32'(local_addr), 32'(exp_locals.pop_front()));
      end
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  // Offer one spike starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic offer(input logic [11:0] a);
    int n = 0;
    spike_addr  = a;
    spike_valid = 1'b1;
    @(negedge CLK);
    while (!spike_ready && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (!spike_ready) chk("offer_timeout", 32'(spike_ready), 32'd1);
    else if (a[11:8] == 4'h0) exp_locals.push_back(a);
    else exp_flits.push_back({4'h0, a});
    sync();
  endtask

  task automatic wait_empty();
    int n = 0;
    @(negedge CLK);
    while (flit_valid && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk("drain_timeout", 32'(flit_valid), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; spike_addr = '0; spike_valid = 1'b0; flit_ready = 1'b0;
    #1;
    chk("rst_ready", 32'(spike_ready), 32'd1);
    chk("rst_flit_valid", 32'(flit_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_sent", 32'(sent_count), 32'd0);
    chk("rst_local_valid", 32'(local_valid), 32'd0);
    chk("rst_stays", 32'(stays), 32'd0);
    sync(); sync();
    RESET = 1'b0;

    // single local spike
    offer(12'h005);
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("local_valid", 32'(local_valid), 32'd1);
    chk("local_addr_005", 32'(local_addr), 32'h005);
    chk("local_stays", 32'(stays), 32'd1);
    chk("local_no_flit", 32'(flit_valid), 32'd0);
    @(negedge CLK);
    chk("local_pulse_end", 32'(local_valid), 32'd0);
    chk("local_addr_hold", 32'(local_addr), 32'h005);

    // back-to-back locals hold local_valid high
    sync();
    offer(12'h011);
    offer(12'h022);
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("b2b_local_valid", 32'(local_valid), 32'd1);
    @(negedge CLK);
    chk("b2b_local_end", 32'(local_valid), 32'd0);

    // single remote spike
    sync();
    offer(12'h3A7);
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("remote_flit", 32'(flit_out), 32'h03A7);
    chk("remote_valid", 32'(flit_valid), 32'd1);
    chk("remote_count", 32'(fifo_count), 32'd1);
    chk("remote_stays", 32'(stays), 32'd0);
    sync();
    flit_ready = 1'b1;
    wait_empty();
    sync();
    chk("empty_hold", 32'(flit_out), 32'(last_flit));
    sync();
    flit_ready = 1'b0;
    chk("empty_ignore_ready", 32'(sent_count), 32'd1);
    chk("empty_hold2", 32'(flit_out), 32'h03A7);

    // fill to full, fifth spike stalls even across a pop
    offer(12'h1A1); offer(12'h2B2); offer(12'h3C3); offer(12'h4D4);
    spike_addr = 12'h5E5;
    @(negedge CLK);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(spike_ready), 32'd0);
    sync();
    @(negedge CLK);
    chk("full_held", 32'(fifo_count), 32'd4);
    sync();
    flit_ready = 1'b1;
    @(negedge CLK);
    chk("full_pop_stall", 32'(spike_ready), 32'd0);
    sync();
    flit_ready = 1'b0;
    @(negedge CLK);
    chk("after_pop_count", 32'(fifo_count), 32'd3);
    chk("after_pop_ready", 32'(spike_ready), 32'd1);
    exp_flits.push_back(16'h05E5);
    sync();
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("fifth_accepted", 32'(fifo_count), 32'd4);
    sync();
    flit_ready = 1'b1;
    wait_empty();
    chk("sent_after_full", 32'(sent_count), 32'd6);

    // drain and pointer wrap after a fresh reset
    sync();
    RESET = 1'b1;
    sync();
    RESET = 1'b0;
    flit_ready = 1'b1;
    for (int i = 0; i < 10; i++) offer(12'h800 | 12'(i));
    spike_valid = 1'b0;
    wait_empty();
    chk("drain_sent", 32'(sent_count), 32'd10);
    chk("drain_count", 32'(fifo_count), 32'd0);

    // simultaneous push and pop at count 2
    sync();
    flit_ready = 1'b0;
    offer(12'h911);
    offer(12'hA22);
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("simul_pre", 32'(fifo_count), 32'd2);
    sync();
    flit_ready = 1'b1;
    offer(12'hB33);
    flit_ready = 1'b0;
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("simul_count", 32'(fifo_count), 32'd2);
    chk("simul_head", 32'(flit_out), 32'h0A22);

    // reset mid-operation
    sync();
    offer(12'hC44);
    offer(12'h0FF);
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_stays", 32'(stays), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    exp_flits.delete();
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_flit_valid", 32'(flit_valid), 32'd0);
    chk("midrst_sent", 32'(sent_count), 32'd0);
    chk("midrst_stays", 32'(stays), 32'd0);
    chk("midrst_ready", 32'(spike_ready), 32'd1);
    spike_addr  = 12'h001;
    spike_valid = 1'b1;
    sync(); sync();
    chk("rst_no_accept_local", 32'(local_valid), 32'd0);
    chk("rst_no_accept_addr", 32'(local_addr), 32'd0);
    spike_valid = 1'b0;
    RESET = 1'b0;

    // resume after reset
    offer(12'hD55);
    spike_valid = 1'b0;
    @(negedge CLK);
    chk("resume_flit", 32'(flit_out), 32'h0D55);
    chk("resume_count", 32'(fifo_count), 32'd1);
    sync();
    flit_ready = 1'b1;
    wait_empty();
    chk("resume_sent", 32'(sent_count), 32'd1);
    chk("flits_left", 32'(exp_flits.size()), 32'd0);
    chk("locals_left", 32'(exp_locals.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
